// File: rtl/pdp8_bin_loader_pkg.sv
// Shared types and constants for the PDP-8 BIN paper-tape loader.
// Holds the loader state encoding and the HI-byte classifier.
package pdp8_loader_pkg;

   typedef enum logic [2:0] {
      LEADER,
      HI,
      LO,
      DONE,
      ERR
   } state_t;

   typedef enum logic [1:0] {
      BC_DATA,
      BC_ORIGIN,
      BC_TRAILER,
      BC_BAD
   } byte_cls_t;

   localparam logic [7:0] LEADER_BYTE = 8'h80;
   localparam logic [1:0] FT_DATA     = 2'b00;
   localparam logic [1:0] FT_ORIGIN   = 2'b01;

   // Leader/trailer code is the only bit7 value allowed in HI position.
   function automatic byte_cls_t classify_hi(input logic [7:0] b);
      byte_cls_t c;
      if (b == LEADER_BYTE)
         c = BC_TRAILER;
      else if (b[7:6] == FT_DATA)
         c = BC_DATA;
      else if (b[7:6] == FT_ORIGIN)
         c = BC_ORIGIN;
      else
         c = BC_BAD;
      return c;
   endfunction

endpackage

// File: rtl/pdp8_bin_loader.sv
// Boot loader: decodes a BIN paper tape into PDP-8 memory writes,
// verifies the checksum and holds the CPU in reset until loaded.
import pdp8_loader_pkg::*;

module pdp8_bin_loader #(
   parameter int MIN_LEADER = 8,
   parameter int ADDR_W     = 12,
   parameter int WORD_W     = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              error
);

   localparam int CW = $clog2(MIN_LEADER + 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     lcnt_q, lcnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [11:0]       csum_q, csum_d;
   logic [11:0]       pend_q, pend_d;
   logic [7:0]        pend_hi_q, pend_hi_d;
   logic [7:0]        pend_lo_q, pend_lo_d;
   logic              pend_v_q, pend_v_d;
   logic [7:0]        hi_q, hi_d;
   logic              org_q, org_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [WORD_W-1:0] mdata_q, mdata_d;

   logic              rdy;
   logic              acc;
   logic              lead_full;
   logic              take_hi;
   logic [11:0]       word;

   assign rdy       = (state_q == LEADER) || (state_q == HI) ||
                      (state_q == LO);
   assign acc       = in_valid && rdy;
   assign lead_full = (lcnt_q >= CW'(MIN_LEADER));
   assign word      = {hi_q[5:0], in_data[5:0]};

   always_comb begin
      state_d   = state_q;
      lcnt_d    = lcnt_q;
      addr_d    = addr_q;
      csum_d    = csum_q;
      pend_d    = pend_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_v_d  = pend_v_q;
      hi_d      = hi_q;
      org_d     = org_q;
      we_d      = 1'b0;
      maddr_d   = maddr_q;
      mdata_d   = mdata_q;
      take_hi   = 1'b0;

      unique case (state_q)
         LEADER: begin
            if (acc) begin
               if (in_data == LEADER_BYTE) begin
                  if (!lead_full)
                     lcnt_d = lcnt_q + CW'(1);
               end else if (lead_full) begin
                  take_hi = 1'b1;
               end else begin
                  lcnt_d = '0;
               end
            end
         end
         HI: begin
            if (acc)
               take_hi = 1'b1;
         end
         LO: begin
            if (acc) begin
               if (in_data[7:6] != FT_DATA) begin
                  state_d = ERR;
               end else begin
                  state_d = HI;
                  // The held word is only known to be data once another pair follows.
                  if (pend_v_q) begin
                     we_d    = 1'b1;
                     maddr_d = addr_q;
                     mdata_d = WORD_W'(pend_q);
                     csum_d  = csum_q + {4'b0, pend_hi_q} + {4'b0, pend_lo_q};
                     addr_d  = addr_q + ADDR_W'(1);
                  end
                  if (org_q) begin
                     csum_d   = csum_d + {4'b0, hi_q} + {4'b0, in_data};
                     addr_d   = ADDR_W'(word);
                     pend_v_d = 1'b0;
                  end else begin
                     pend_d    = word;
                     pend_hi_d = hi_q;
                     pend_lo_d = in_data;
                     pend_v_d  = 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase

      if (take_hi) begin
         unique case (classify_hi(in_data))
            BC_DATA, BC_ORIGIN: begin
               hi_d    = in_data;
               org_d   = (in_data[7:6] == FT_ORIGIN);
               state_d = LO;
            end
            BC_TRAILER: begin
               state_d = (pend_v_q && (pend_q == csum_q)) ? DONE : ERR;
            end
            default: state_d = ERR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= LEADER;
         lcnt_q    <= '0;
         addr_q    <= '0;
         csum_q    <= '0;
         pend_q    <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_v_q  <= 1'b0;
         hi_q      <= '0;
         org_q     <= 1'b0;
         we_q      <= 1'b0;
         maddr_q   <= '0;
         mdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         lcnt_q    <= lcnt_d;
         addr_q    <= addr_d;
         csum_q    <= csum_d;
         pend_q    <= pend_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_v_q  <= pend_v_d;
         hi_q      <= hi_d;
         org_q     <= org_d;
         we_q      <= we_d;
         maddr_q   <= maddr_d;
         mdata_q   <= mdata_d;
      end
   end

   assign in_ready  = rdy && !rst;
   assign mem_we    = we_q;
   assign mem_addr  = maddr_q;
   assign mem_wdata = mdata_q;
   assign done      = (state_q == DONE);
   assign error     = (state_q == ERR);
   assign cpu_rst   = (state_q != DONE);

endmodule

// File: tb/tb_pdp8_bin_loader.sv
// Directed bench for the PDP-8 BIN tape loader.
// Tapes and expected writes are hand-computed constants.
module tb_pdp8_bin_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [11:0] mem_wdata;
   logic        cpu_rst;
   logic        done;
   logic        error;

   int n_cmp = 0;
   int n_bad = 0;

   logic [11:0] wa[$];
   logic [11:0] wd[$];

   pdp8_bin_loader #(
      .MIN_LEADER(8),
      .ADDR_W(12),
      .WORD_W(12)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_rst(cpu_rst),
      .done(done),
      .error(error)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (mem_we) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_wdata);
      end

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_leader(input int n);
      for (int i = 0; i < n; i++)
         send(8'h80);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wa.delete();
      wd.delete();
   endtask

   task automatic send_nominal();
      send_leader(8);
      send(8'h41); send(8'h00);
      send(8'h0A); send(8'h3F);
      send(8'h00); send(8'h01);
      send(8'h02); send(8'h0B);
      send(8'h80);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error}
          !== {1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_outputs rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b",
                  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error);
      end
      rst = 1'b0;
      wa.delete();
      wd.delete();
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_ready_after got %b want 1", in_ready);
      end
   endtask

   task automatic test_nominal();
      do_reset();
      send_leader(8);
      send(8'h41); send(8'h00);
      send(8'h0A); send(8'h3F);
      n_cmp++;
      if (mem_we !== 1'b0) begin
         n_bad++;
         $display("FAIL nom_no_early_write got %b want 0", mem_we);
      end
      send(8'h00); send(8'h01);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h040, 12'h2BF}) begin
         n_bad++;
         $display("FAIL nom_write0 we=%b a=%h d=%h want 1 040 2BF",
                  mem_we, mem_addr, mem_wdata);
      end
      send(8'h02); send(8'h0B);
      n_cmp++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h041, 12'h001}) begin
         n_bad++;
         $display("FAIL nom_write1 we=%b a=%h d=%h want 1 041 001",
                  mem_we, mem_addr, mem_wdata);
      end
      n_cmp++;
      if ({cpu_rst, done} !== 2'b10) begin
         n_bad++;
         $display("FAIL nom_pre_trailer crst=%b done=%b want 1 0", cpu_rst, done);
      end
      send(8'h80);
      n_cmp++;
      if ({cpu_rst, done, error, in_ready, mem_we} !== 5'b01000) begin
         n_bad++;
         $display("FAIL nom_after_trailer crst=%b done=%b err=%b rdy=%b we=%b",
                  cpu_rst, done, error, in_ready, mem_we);
      end
      idle(3);
      n_cmp++;
      if (wa.size() !== 2) begin
         n_bad++;
         $display("FAIL nom_write_count got %0d want 2", wa.size());
      end
   endtask

   task automatic test_bad_checksum();
      do_reset();
      send_leader(8);
      send(8'h41); send(8'h00);
      send(8'h0A); send(8'h3F);
      send(8'h00); send(8'h01);
      send(8'h02); send(8'h0C);
      send(8'h80);
      idle(3);
      n_cmp++;
      if ({error, done, cpu_rst, in_ready} !== 4'b1010) begin
         n_bad++;
         $display("FAIL badck_flags err=%b done=%b crst=%b rdy=%b want 1 0 1 0",
                  error, done, cpu_rst, in_ready);
      end
      n_cmp++;
      if (wa.size() !== 2) begin
         n_bad++;
         $display("FAIL badck_write_count got %0d want 2", wa.size());
      end else begin
         n_cmp++;
         if ({wa[0], wd[0], wa[1], wd[1]} !==
             {12'h040, 12'h2BF, 12'h041, 12'h001}) begin
            n_bad++;
            $display("FAIL badck_writes got %h=%h %h=%h want 040=2BF 041=001",
                     wa[0], wd[0], wa[1], wd[1]);
         end
      end
   endtask

   task automatic test_noise_leader();
      for (int k = 0; k < 2; k++) begin
         do_reset();
         if (k == 0) begin
            send(8'h80); send(8'h80); send(8'h13);
         end else begin
            send_leader(7);
            send(8'h41);
         end
         send_nominal();
         idle(2);
         n_cmp++;
         if ({done, error, cpu_rst} !== 3'b100) begin
            n_bad++;
            $display("FAIL noise%0d_flags done=%b err=%b crst=%b want 1 0 0",
                     k, done, error, cpu_rst);
         end
         n_cmp++;
         if (wa.size() !== 2) begin
            n_bad++;
            $display("FAIL noise%0d_write_count got %0d want 2", k, wa.size());
         end else begin
            n_cmp++;
            if ({wa[0], wd[0], wa[1], wd[1]} !==
                {12'h040, 12'h2BF, 12'h041, 12'h001}) begin
               n_bad++;
               $display("FAIL noise%0d_writes got %h=%h %h=%h", k,
                        wa[0], wd[0], wa[1], wd[1]);
            end
         end
      end
   endtask

   task automatic test_format_errors();
      for (int k = 0; k < 4; k++) begin
         do_reset();
         send_leader(8);
         case (k)
            0: begin send(8'h0A); send(8'h41); end
            1: begin send(8'h0A); send(8'h80); end
            2: send(8'hC5);
            default: begin send(8'h41); send(8'h00); send(8'h80); end
         endcase
         n_cmp++;
         if ({error, done, cpu_rst, in_ready} !== 4'b1010) begin
            n_bad++;
            $display("FAIL fmt%0d_flags err=%b done=%b crst=%b rdy=%b want 1 0 1 0",
                     k, error, done, cpu_rst, in_ready);
         end
         send(8'h00); send(8'h01); send(8'h00); send(8'h02);
         send(8'h00); send(8'h03);
         idle(2);
         n_cmp++;
         if ({wa.size() == 0, error} !== 2'b11) begin
            n_bad++;
            $display("FAIL fmt%0d_no_writes writes=%0d err=%b want 0 1",
                     k, wa.size(), error);
         end
      end
   endtask

   task automatic test_wrap_gaps();
      logic [7:0] tape [12];
      tape = '{8'h7F, 8'h3F, 8'h04, 8'h23, 8'h11, 8'h16,
               8'h1E, 8'h09, 8'h04, 8'h33, 8'h80, 8'h80};
      do_reset();
      send_leader(8);
      for (int i = 0; i < 11; i++) begin
         send(tape[i]);
         in_data = 8'h5A;
         idle(i % 3);
      end
      idle(2);
      n_cmp++;
      if ({done, error, cpu_rst} !== 3'b100) begin
         n_bad++;
         $display("FAIL wrap_flags done=%b err=%b crst=%b want 1 0 0",
                  done, error, cpu_rst);
      end
      n_cmp++;
      if (wa.size() !== 3) begin
         n_bad++;
         $display("FAIL wrap_write_count got %0d want 3", wa.size());
      end else begin
         n_cmp++;
         if ({wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]} !==
             {12'hFFF, 12'h123, 12'h000, 12'h456, 12'h001, 12'h789}) begin
            n_bad++;
            $display("FAIL wrap_writes got %h=%h %h=%h %h=%h",
                     wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]);
         end
      end
   endtask

   task automatic test_reset_midload();
      do_reset();
      send_leader(8);
      send(8'h41); send(8'h00);
      send(8'h0A); send(8'h3F);
      send(8'h00); send(8'h01);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error}
          !== {1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL midrst_outputs rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b",
                  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error);
      end
      rst = 1'b0;
      wa.delete();
      wd.delete();
      send_nominal();
      idle(2);
      n_cmp++;
      if ({done, error, cpu_rst, wa.size() == 2} !== 4'b1001) begin
         n_bad++;
         $display("FAIL midrst_reload done=%b err=%b crst=%b writes=%0d",
                  done, error, cpu_rst, wa.size());
      end else begin
         n_cmp++;
         if ({wa[0], wd[0], wa[1], wd[1]} !==
             {12'h040, 12'h2BF, 12'h041, 12'h001}) begin
            n_bad++;
            $display("FAIL midrst_writes got %h=%h %h=%h",
                     wa[0], wd[0], wa[1], wd[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_bad_checksum();
      test_noise_leader();
      test_format_errors();
      test_wrap_gaps();
      test_reset_midload();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
